// File: rtl/pipeline_ctrl.sv
// Stage sequencer for the 5-stage pipeline: reset sequencing, run/halt/step
// debug control, RAW stall and branch flush handling, and performance counters.
module pipeline_ctrl #(
  parameter int RST_CYCLES     = 4,
  parameter bit WB_WRITE_FIRST = 1'b0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             step_req,
  input  logic [31:0]      inst_data_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic             is_branch_id,
  input  logic             is_branch_exe,
  input  logic [4:0]       regw_addr_exe,
  input  logic             wb_wen_exe,
  input  logic             is_branch_mem,
  input  logic [4:0]       regw_addr_mem,
  input  logic             wb_wen_mem,
  input  logic [4:0]       regw_addr_wb,
  input  logic             wb_wen_wb,
  output logic             if_rst,
  output logic             id_rst,
  output logic             exe_rst,
  output logic             mem_rst,
  output logic             wb_rst,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_STEP = 2'd3;

  localparam logic [7:0] INIT_LAST = 8'(RST_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] init_cnt;
  logic       step_req_d;
  logic       step_edge;
  logic       active;

  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       raw;
  logic       br_early;
  logic       stall_evt;
  logic       flush_evt;
  logic       unused_inst_bits;

  assign rs               = inst_data_id[25:21];
  assign rt               = inst_data_id[20:16];
  assign unused_inst_bits = ^{inst_data_id[31:26], inst_data_id[15:0]};

  assign step_edge  = step_req & ~step_req_d;
  assign active     = (state == ST_RUN) || (state == ST_STEP);
  assign ctrl_state = state;

  // Register-dependency check of the ID source registers against in-flight writers.
  always_comb begin
    rs_hit = (rs != 5'd0) &&
             ((wb_wen_exe && (rs == regw_addr_exe)) ||
              (wb_wen_mem && (rs == regw_addr_mem)) ||
              (!WB_WRITE_FIRST && wb_wen_wb && (rs == regw_addr_wb)));
    rt_hit = (rt != 5'd0) &&
             ((wb_wen_exe && (rt == regw_addr_exe)) ||
              (wb_wen_mem && (rt == regw_addr_mem)) ||
              (!WB_WRITE_FIRST && wb_wen_wb && (rt == regw_addr_wb)));
    raw    = (rs_used_id && rs_hit) || (rt_used_id && rt_hit);
  end

  // A branch in ID or EXE holds IF; a branch in MEM lets IF load the target.
  assign br_early  = is_branch_id || is_branch_exe;
  assign stall_evt = active && raw;
  assign flush_evt = active && !raw && (br_early || is_branch_mem);

  // Debug FSM next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == INIT_LAST) state_nxt = run_en ? ST_RUN : ST_HALT;
      ST_RUN:  if (!run_en) state_nxt = ST_HALT;
      ST_HALT: begin
        if (run_en)         state_nxt = ST_RUN;
        else if (step_edge) state_nxt = ST_STEP;
      end
      ST_STEP: state_nxt = run_en ? ST_RUN : ST_HALT;
      default: state_nxt = ST_INIT;
    endcase
  end

  // State, reset-sequence counter and step edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= 8'd0;
      step_req_d <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_req_d <= step_req;
      if (state == ST_INIT) init_cnt <= init_cnt + 8'd1;
    end
  end

  // Saturating stall/flush counters, only counting while the pipeline advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_evt && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush_evt && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

  // Stage control outputs; RAW stalls take priority over branch handling.
  always_comb begin
    if_rst  = 1'b0;
    id_rst  = 1'b0;
    exe_rst = 1'b0;
    mem_rst = 1'b0;
    wb_rst  = 1'b0;
    if_en   = 1'b0;
    id_en   = 1'b0;
    exe_en  = 1'b0;
    mem_en  = 1'b0;
    wb_en   = 1'b0;
    if (state == ST_INIT) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (active) begin
      if_en  = 1'b1;
      id_en  = 1'b1;
      exe_en = 1'b1;
      mem_en = 1'b1;
      wb_en  = 1'b1;
      if (raw) begin
        if_en   = 1'b0;
        id_en   = 1'b0;
        exe_rst = 1'b1;
      end else if (br_early) begin
        if_en  = 1'b0;
        id_rst = 1'b1;
      end else if (is_branch_mem) begin
        id_rst = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected stage-control words are queued
// as each step is driven and compared when the outputs settle.
module tb_pipeline_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             run_en;
  logic             step_req;
  logic [31:0]      inst_data_id;
  logic             rs_used_id;
  logic             rt_used_id;
  logic             is_branch_id;
  logic             is_branch_exe;
  logic [4:0]       regw_addr_exe;
  logic             wb_wen_exe;
  logic             is_branch_mem;
  logic [4:0]       regw_addr_mem;
  logic             wb_wen_mem;
  logic [4:0]       regw_addr_wb;
  logic             wb_wen_wb;
  logic             if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic             if_en, id_en, exe_en, mem_en, wb_en;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // {ctrl_state, if/id/exe/mem/wb rst, if/id/exe/mem/wb en}
  localparam logic [11:0] O_INIT   = {2'd0, 5'b11111, 5'b00000};
  localparam logic [11:0] O_RUN    = {2'd1, 5'b00000, 5'b11111};
  localparam logic [11:0] O_STALL  = {2'd1, 5'b00100, 5'b00111};
  localparam logic [11:0] O_BR     = {2'd1, 5'b01000, 5'b01111};
  localparam logic [11:0] O_BR_MEM = {2'd1, 5'b01000, 5'b11111};
  localparam logic [11:0] O_HALT   = {2'd2, 5'b00000, 5'b00000};
  localparam logic [11:0] O_STEP   = {2'd3, 5'b00000, 5'b11111};

  logic [11:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  pipeline_ctrl #(.RST_CYCLES(4), .WB_WRITE_FIRST(1'b0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
    .inst_data_id(inst_data_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .is_branch_id(is_branch_id), .is_branch_exe(is_branch_exe),
    .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .is_branch_mem(is_branch_mem), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .ctrl_state(ctrl_state), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] observed();
    return {ctrl_state, if_rst, id_rst, exe_rst, mem_rst, wb_rst,
            if_en, id_en, exe_en, mem_en, wb_en};
  endfunction

  // Pop the oldest expectation and compare with the current outputs.
  task automatic compare_out(input string tag);
    logic [11:0] obs;
    logic [11:0] want;
    obs  = observed();
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs,
                           input logic [CNT_W-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // One clock: queue the expectation, sample at the falling edge, end 1ns past the next rise.
  task automatic cycle(input logic [11:0] exp, input string tag);
    exp_q.push_back(exp);
    @(negedge clk);
    compare_out(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    inst_data_id  = 32'h0;
    rs_used_id    = 1'b0;
    rt_used_id    = 1'b0;
    is_branch_id  = 1'b0;
    is_branch_exe = 1'b0;
    is_branch_mem = 1'b0;
    regw_addr_exe = 5'd0;
    wb_wen_exe    = 1'b0;
    regw_addr_mem = 5'd0;
    wb_wen_mem    = 1'b0;
    regw_addr_wb  = 5'd0;
    wb_wen_wb     = 1'b0;
  endtask

  // add $10, $8, $9
  task automatic load_add();
    inst_data_id = {6'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
    rs_used_id   = 1'b1;
    rt_used_id   = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    run_en   = 1'b1;
    step_req = 1'b0;
    clear_hazards();
    @(posedge clk);
    #1;

    cycle(O_INIT, "in_reset");
    check_cnt("stall_reset", stall_count, 16'd0);
    check_cnt("flush_reset", flush_count, 16'd0);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(O_INIT, "init_hold");
    cycle(O_RUN, "run_entry");

    // RAW against EXE writer, two cycles
    load_add();
    regw_addr_exe = 5'd8;
    wb_wen_exe    = 1'b1;
    cycle(O_STALL, "raw_exe_1"); exp_stall++;
    cycle(O_STALL, "raw_exe_2"); exp_stall++;
    check_cnt("stall_after_exe", stall_count, exp_stall);

    clear_hazards(); load_add();
    regw_addr_mem = 5'd8; wb_wen_mem = 1'b1;
    cycle(O_STALL, "raw_mem"); exp_stall++;

    clear_hazards(); load_add();
    regw_addr_wb = 5'd8; wb_wen_wb = 1'b1;
    cycle(O_STALL, "raw_wb"); exp_stall++;

    clear_hazards(); load_add();
    regw_addr_exe = 5'd9; wb_wen_exe = 1'b1;
    cycle(O_STALL, "raw_rt"); exp_stall++;
    check_cnt("stall_after_raw", stall_count, exp_stall);

    // Non-hazards: rt not read, writer disabled, destination $0
    rt_used_id = 1'b0;
    cycle(O_RUN, "rt_unused");
    clear_hazards(); load_add();
    regw_addr_exe = 5'd8; wb_wen_exe = 1'b0;
    cycle(O_RUN, "wen_off");
    clear_hazards();
    inst_data_id = {6'd0, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
    rs_used_id = 1'b1; rt_used_id = 1'b1;
    regw_addr_exe = 5'd0; wb_wen_exe = 1'b1;
    regw_addr_mem = 5'd0; wb_wen_mem = 1'b1;
    cycle(O_RUN, "dest_zero");
    check_cnt("stall_no_hazard", stall_count, exp_stall);
    check_cnt("flush_no_branch", flush_count, exp_flush);

    // Branch walking down ID, EXE, MEM
    clear_hazards();
    is_branch_id = 1'b1;
    cycle(O_BR, "br_id"); exp_flush++;
    is_branch_id = 1'b0; is_branch_exe = 1'b1;
    cycle(O_BR, "br_exe"); exp_flush++;
    is_branch_exe = 1'b0; is_branch_mem = 1'b1;
    cycle(O_BR_MEM, "br_mem"); exp_flush++;
    check_cnt("flush_branch", flush_count, 16'd3);

    // RAW outranks a branch in ID
    clear_hazards(); load_add();
    regw_addr_exe = 5'd8; wb_wen_exe = 1'b1; is_branch_id = 1'b1;
    cycle(O_STALL, "raw_over_br"); exp_stall++;
    check_cnt("flush_raw_br", flush_count, exp_flush);
    check_cnt("stall_raw_br", stall_count, exp_stall);

    // Halt, then a held step request gives a single step
    clear_hazards();
    run_en = 1'b0;
    cycle(O_RUN, "run_last");
    cycle(O_HALT, "halt");
    step_req = 1'b1;
    cycle(O_HALT, "step_seen");
    cycle(O_STEP, "step_cycle");
    cycle(O_HALT, "step_held_1");
    cycle(O_HALT, "step_held_2");
    cycle(O_HALT, "step_held_3");
    step_req = 1'b0;
    cycle(O_HALT, "step_released");

    // Back to RUN, stall, then asynchronous reset mid-cycle
    run_en = 1'b1;
    cycle(O_HALT, "halt_to_run");
    load_add();
    regw_addr_exe = 5'd8; wb_wen_exe = 1'b1;
    cycle(O_STALL, "pre_rst_stall"); exp_stall++;
    check_cnt("stall_pre_rst", stall_count, exp_stall);
    #2;
    rst = 1'b1;
    exp_q.push_back(O_INIT);
    #1;
    compare_out("async_rst");
    check_cnt("stall_async", stall_count, 16'd0);
    check_cnt("flush_async", flush_count, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_hazards();
    cycle(O_INIT, "post_rst_init");

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stage sequencer for the 5-stage MIPS pipeline datapath. Drives every stage's `*_rst` / `*_en` pair.
- The datapath has no forwarding, so this block resolves read-after-write (RAW) hazards by stalling and inserting bubbles.
- It resolves jump/branch hazards by holding IF until the branch resolves in MEM.
- It provides a run/halt/single-step debug FSM and saturating stall/flush performance counters.
- It sits beside the decoder, between the datapath's hazard feedback outputs and its stage control inputs.

Parameters:
- RST_CYCLES, 4: cycles all stages are held in reset after `rst` deasserts (range 1..255).
- WB_WRITE_FIRST, 0: 1 means the regfile bypasses WB writes to same-cycle reads, so the WB stage is excluded from hazard checks.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- run_en  in  1  level; 1 = free-run, 0 = halt.
- step_req  in  1  single-step request, rising-edge detected internally.
- inst_data_id  in  32  ID-stage instruction; rs = [25:21], rt = [20:16].
- rs_used_id  in  1  decoder: ID instruction reads rs.
- rt_used_id  in  1  decoder: ID instruction reads rt.
- is_branch_id  in  1  decoder: ID instruction is jump/branch (`pc_src_ctrl` != `PC_NEXT`).
- is_branch_exe  in  1  jump/branch in EXE.
- regw_addr_exe  in  5  EXE destination register.
- wb_wen_exe  in  1  EXE writes a register.
- is_branch_mem  in  1  jump/branch in MEM.
- regw_addr_mem  in  5  MEM destination register.
- wb_wen_mem  in  1  MEM writes a register.
- regw_addr_wb  in  5  WB destination register.
- wb_wen_wb  in  1  WB writes a register.
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage resets.
- if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables.
- ctrl_state  out  2  0 = INIT, 1 = RUN, 2 = HALT, 3 = STEP.
- stall_count  out  CNT_W  cycles lost to RAW stalls.
- flush_count  out  CNT_W  bubbles inserted for branches.

Behaviour:
- Reset (`rst` = 1, asynchronous):
  - state = INIT; init counter = 0.
  - `step_req` delay register = 0; both performance counters = 0.
  - Outputs: all `*_rst` = 1, all `*_en` = 0.
- INIT:
  - All `*_rst` = 1, all `*_en` = 0.
  - The counter increments each cycle. When it reaches RST_CYCLES-1, the next state is RUN if `run_en` = 1, else HALT.
- HALT:
  - All `*_rst` = 0, all `*_en` = 0; the pipeline is frozen.
  - Goes to RUN when `run_en` = 1.
  - Otherwise goes to STEP on a `step_req` rising edge (`step_req` & ~`step_req_d`).
- STEP:
  - Applies exactly one cycle of RUN output logic, then returns to HALT.
  - Goes to RUN instead if `run_en` = 1.
- RUN:
  - Goes to HALT when `run_en` = 0, evaluated at the edge; the current cycle completes with RUN outputs.
  - Step edges are ignored in RUN.
- RUN/STEP output logic (combinational from state and inputs, same cycle):
  - Defaults: all `*_en` = 1, all `*_rst` = 0.
  - match(a) = a != 0 and ((`wb_wen_exe` and a == `regw_addr_exe`) or (`wb_wen_mem` and a == `regw_addr_mem`) or (!WB_WRITE_FIRST and `wb_wen_wb` and a == `regw_addr_wb`)).
  - raw = (`rs_used_id` and match(rs)) or (`rt_used_id` and match(rt)).
  - Priority 1, raw = 1: `if_en` = 0, `id_en` = 0, `exe_rst` = 1 (bubble into EXE). `stall_count` += 1.
  - Priority 2, `is_branch_exe` or `is_branch_id`: `if_en` = 0, `id_rst` = 1. `flush_count` += 1.
  - Priority 3, `is_branch_mem`: `if_en` = 1 (datapath loads the branch target), `id_rst` = 1. `flush_count` += 1.
  - raw has priority over a branch in ID: the branch waits for its operands.
  - `exe_en`, `mem_en`, `wb_en` remain 1 in all RUN cases.
- Counters:
  - Update only in RUN/STEP, and saturate at all-ones.
- Edge detection:
  - `step_req_d` is registered every cycle in every state.
  - A `step_req` held high produces one STEP only.
- Async `rst` mid-operation immediately forces INIT outputs, regardless of state.

Test Plan:
- Reset released with RST_CYCLES = 4, `run_en` = 1 -> `*_rst` = 1 for 4 cycles after deassert, then `ctrl_state` = 1 with all `*_en` = 1.
- RUN, ID inst `add` with rs = 8 and `rs_used_id` = 1; `regw_addr_exe` = 8, `wb_wen_exe` = 1 -> `if_en` = `id_en` = 0, `exe_rst` = 1. Same check for MEM and for WB (WB only with WB_WRITE_FIRST = 0). `stall_count` increments per cycle. No stall when the destination register is 0.
- Branch: `is_branch_id` 1 cycle, then `is_branch_exe` 1 cycle, then `is_branch_mem` 1 cycle -> `if_en` sequence 0, 0, 1 and `id_rst` = 1 on all three cycles; `flush_count` = 3.
- raw and `is_branch_id` both 1 -> stall response only (`exe_rst` = 1, `id_rst` = 0); `flush_count` unchanged.
- `run_en` = 0, then `step_req` held high for 5 cycles -> exactly one cycle with `*_en` = 1 and `ctrl_state` = 3, then HALT with `*_en` = 0.
- Async `rst` pulse mid-stall in RUN -> within the same cycle all `*_rst` = 1, `*_en` = 0; counters = 0; `ctrl_state` = 0.
